if_fetch: RTL

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC,

---
 rtl/if_fetch_pkg.sv | 26 ++
 rtl/if_inst_fifo.sv | 59 +++++
 rtl/if_fetch.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding, the {pc, inst} buffer entry layout and the nop word.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0]      INST_NOP  = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    IF_STATE_FETCH = 1'b0,
    IF_STATE_FLUSH = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Sequential fetch address; natural 32-bit overflow wraps 0xFFFF_FFFC to 0.
  function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// Small synchronous FIFO with push, pop and flush; flush (or rst) empties it and wins
// over a simultaneous push. The head word is presented combinationally.
module if_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues req/gnt/rvalid fetches and buffers {pc, inst}.
// Define IF_FETCH_CNT_EN to add fetch_cnt_o, a count of instructions handed to IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e    r_state;
  if_state_e    w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;

  logic         w_req;
  logic         w_gnt;
  logic         w_rvalid;
  logic         w_push;
  logic         w_pop;
  logic         w_credit_ok;
  logic [CW:0]  w_credit_used;
  logic [CW-1:0] w_out_next;

  logic [31:0]  w_infl_pc;
  logic [CW-1:0] w_infl_count;
  logic         w_infl_full;
  logic         w_infl_empty;

  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;
  logic [CW-1:0] w_fifo_count;
  logic         w_fifo_full;
  logic         w_fifo_empty;

  // Each slot is reserved at request time so a returning response always has room.
  assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, w_infl_count};
  assign w_credit_ok   = (w_credit_used < (CW + 1)'(FIFO_DEPTH));

  assign w_req    = !rst && (r_state == IF_STATE_FETCH) && w_credit_ok
                    && !w_infl_full && !w_fifo_full;
  assign w_gnt    = w_req && imem_gnt_i;
  assign w_rvalid = imem_rvalid_i && !w_infl_empty;

  assign w_out_next = w_infl_count + CW'(w_gnt) - CW'(w_rvalid);

  assign w_push = w_rvalid && (r_state == IF_STATE_FETCH);
  assign w_pop  = if_valid_o && !stall_i && !branch_flag_i;

  assign w_push_entry.pc   = w_infl_pc;
  assign w_push_entry.inst = imem_rdata_i;

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;

  assign if_valid_o = !w_fifo_empty;
  assign if_pc_o    = if_valid_o ? w_head.pc   : ZERO_WORD;
  assign if_inst_o  = if_valid_o ? w_head.inst : INST_NOP;

  // PCs of granted-but-unanswered requests; its occupancy is the outstanding count.
  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_gnt),
    .i_data  (r_pc),
    .i_pop   (w_rvalid),
    .i_flush (1'b0),
    .o_head  (w_infl_pc),
    .o_count (w_infl_count),
    .o_full  (w_infl_full),
    .o_empty (w_infl_empty)
  );

  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (branch_flag_i),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IF_STATE_FETCH: begin
        // A grant in the redirect cycle still belongs to the old path.
        if (branch_flag_i && (w_out_next != '0)) begin
          w_state_next = IF_STATE_FLUSH;
        end
      end
      IF_STATE_FLUSH: begin
        if (w_out_next == '0) begin
          w_state_next = IF_STATE_FETCH;
        end
      end
      default: w_state_next = IF_STATE_FETCH;
    endcase
  end

  always_comb begin
    w_pc_next = r_pc;
    if (branch_flag_i) begin
      w_pc_next = branch_target_i;
    end else if (w_gnt) begin
      w_pc_next = next_pc(r_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IF_STATE_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
    end else if (w_pop) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule
